// File: rtl/aes_timer_pkg.sv
// aes_timer_pkg: shared encodings for the AES interval-timer host.
// Holds the op codes, the timer register map, and the control/status bit positions.
package aes_timer_pkg;

   // Request op codes presented on req_op
   typedef enum logic [1:0] {
      OP_START = 2'd0,
      OP_SNAP  = 2'd1,
      OP_STOP  = 2'd2,
      OP_CLEAR = 2'd3
   } op_e;

   // Timer s1 register map (16-bit registers)
   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
   localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
   localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
   localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

   // Control register bit positions
   localparam int CTRL_STOP_BIT  = 3;
   localparam int CTRL_START_BIT = 2;
   localparam int CTRL_CONT_BIT  = 1;
   localparam int CTRL_ITO_BIT   = 0;

   // Status register bit positions
   localparam int STATUS_TO_BIT  = 0;
   localparam int STATUS_RUN_BIT = 1;

   // Builds a control-register write value from its individual bits
   function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                             input logic cont, input logic ito);
      logic [15:0] w;
      w                 = '0;
      w[CTRL_STOP_BIT]  = stop;
      w[CTRL_START_BIT] = start;
      w[CTRL_CONT_BIT]  = cont;
      w[CTRL_ITO_BIT]   = ito;
      return w;
   endfunction

endpackage

// File: rtl/aes_timer_host.sv
// aes_timer_host: Avalon-MM master that turns START/SNAP/STOP/CLEAR requests from
// the AES control FSM into single-cycle accesses on the interval timer's s1 port,
// and returns the 32-bit snapshot, elapsed ticks and status flags.
module aes_timer_host
   import aes_timer_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 1,
   parameter bit          CONT_MODE    = 1'b1,
   parameter bit          IRQ_ENABLE   = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_period,
   output logic        req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_count,
   output logic [31:0] rsp_elapsed,
   output logic        rsp_timeout,
   output logic        rsp_running,
   input  logic        irq,
   output logic        irq_pending,
   output logic [2:0]  avm_address,
   output logic        avm_chipselect,
   output logic        avm_write_n,
   output logic [15:0] avm_writedata,
   input  logic [15:0] avm_readdata
);

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WR_SNAP,
      S_RD_SL, S_RD_SH, S_RD_ST, S_WAIT, S_WR_ST, S_RESP
   } state_e;

   // Which read the WAIT state is completing
   typedef enum logic [1:0] {SEL_SL, SEL_SH, SEL_ST} rd_sel_e;

   localparam int unsigned WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY - 1);

   localparam logic [15:0] CTRL_START_WORD = ctrl_word(1'b0, 1'b1, CONT_MODE, IRQ_ENABLE);
   localparam logic [15:0] CTRL_STOP_WORD  = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);

   state_e            state;
   rd_sel_e           rd_sel;
   logic [WAIT_W-1:0] wait_cnt;
   logic [31:0]       period_latched;
   logic [15:0]       snap_l;
   logic [15:0]       snap_h;

   // Op sequencer: state and every output are registered here; `state` names the
   // bus cycle currently being driven, so each transition schedules the next access.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         rd_sel         <= SEL_SL;
         wait_cnt       <= '0;
         period_latched <= '0;
         snap_l         <= '0;
         snap_h         <= '0;
         req_ready      <= 1'b1;
         rsp_valid      <= 1'b0;
         rsp_count      <= '0;
         rsp_elapsed    <= '0;
         rsp_timeout    <= 1'b0;
         rsp_running    <= 1'b0;
         irq_pending    <= 1'b0;
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_address    <= ADDR_STATUS;
         avm_writedata  <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; a later assignment to the same
         // register in this block overrides an earlier one, which is how the bus-idle
         // defaults below and the CLEAR-beats-irq rule take effect.
         avm_chipselect <= 1'b0;
         avm_write_n    <= 1'b1;
         avm_address    <= ADDR_STATUS;
         avm_writedata  <= '0;
         if (irq) irq_pending <= 1'b1;

         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  // Every op starts with a register write
                  req_ready      <= 1'b0;
                  avm_chipselect <= 1'b1;
                  avm_write_n    <= 1'b0;
                  case (req_op)
                     OP_START: begin
                        period_latched <= req_period;
                        avm_address    <= ADDR_PERIOD_L;
                        avm_writedata  <= req_period[15:0];
                        state          <= S_WR_PL;
                     end
                     OP_SNAP: begin
                        avm_address <= ADDR_SNAP_L;
                        state       <= S_WR_SNAP;
                     end
                     OP_STOP: begin
                        avm_address   <= ADDR_CONTROL;
                        avm_writedata <= CTRL_STOP_WORD;
                        state         <= S_WR_CTRL;
                     end
                     default: begin  // OP_CLEAR
                        avm_address <= ADDR_STATUS;
                        state       <= S_WR_ST;
                     end
                  endcase
               end
            end
            S_WR_PL: begin
               avm_chipselect <= 1'b1;
               avm_write_n    <= 1'b0;
               avm_address    <= ADDR_PERIOD_H;
               avm_writedata  <= period_latched[31:16];
               state          <= S_WR_PH;
            end
            S_WR_PH: begin
               // Control write immediately after period_h: the start strobe must
               // override the stop the timer forces on a period load.
               avm_chipselect <= 1'b1;
               avm_write_n    <= 1'b0;
               avm_address    <= ADDR_CONTROL;
               avm_writedata  <= CTRL_START_WORD;
               state          <= S_WR_CTRL;
            end
            S_WR_CTRL: begin
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_WR_SNAP: begin
               avm_chipselect <= 1'b1;
               avm_address    <= ADDR_SNAP_L;
               state          <= S_RD_SL;
            end
            S_RD_SL: begin
               rd_sel   <= SEL_SL;
               wait_cnt <= WAIT_LOAD;
               state    <= S_WAIT;
            end
            S_RD_SH: begin
               rd_sel   <= SEL_SH;
               wait_cnt <= WAIT_LOAD;
               state    <= S_WAIT;
            end
            S_RD_ST: begin
               rd_sel   <= SEL_ST;
               wait_cnt <= WAIT_LOAD;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - 1'b1;
               end else begin
                  // Last wait cycle: readdata is valid now
                  unique case (rd_sel)
                     SEL_SL: begin
                        snap_l         <= avm_readdata;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_SNAP_H;
                        state          <= S_RD_SH;
                     end
                     SEL_SH: begin
                        snap_h         <= avm_readdata;
                        avm_chipselect <= 1'b1;
                        avm_address    <= ADDR_STATUS;
                        state          <= S_RD_ST;
                     end
                     default: begin  // SEL_ST
                        rsp_count   <= {snap_h, snap_l};
                        rsp_elapsed <= period_latched - {snap_h, snap_l};
                        rsp_timeout <= avm_readdata[STATUS_TO_BIT];
                        rsp_running <= avm_readdata[STATUS_RUN_BIT];
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                     end
                  endcase
               end
            end
            S_WR_ST: begin
               irq_pending <= 1'b0;
               rsp_valid   <= 1'b1;
               state       <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid   <= 1'b0;
                  rsp_count   <= '0;
                  rsp_elapsed <= '0;
                  rsp_timeout <= 1'b0;
                  rsp_running <= 1'b0;
                  req_ready   <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            default: begin
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
